// File: rtl/sa_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sa_skew_feeder_pkg
// Brief   : Shared FP constants, feeder state encoding and clog2 helper.
// Revision: 1.0
// ============================================================================
package sa_skew_feeder_pkg;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_EMPTY  = 3'd0,
      ST_LOAD   = 3'd1,
      ST_FULL   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4
   } feeder_state_t;

   // Ceiling log2, never below 1 so counters always have at least one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sa_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module  : sa_skew_feeder_if
// Brief   : Load handshake and skewed feed bus of one array-edge feeder.
// Revision: 1.0
// ============================================================================
interface sa_skew_feeder_if #(
   parameter int N  = 4,
   parameter int DW = 32
);
   logic            LD_VALID;
   logic            LD_READY;
   logic [N*DW-1:0] LD_DATA;
   logic            START;
   logic [N*DW-1:0] FEED;
   logic            FEED_VLD;
   logic            BUSY;
   logic            DONE;

   modport master (
      output LD_VALID, LD_DATA, START,
      input  LD_READY, FEED, FEED_VLD, BUSY, DONE
   );

   modport slave (
      input  LD_VALID, LD_DATA, START,
      output LD_READY, FEED, FEED_VLD, BUSY, DONE
   );
endinterface
`default_nettype wire

// File: rtl/sa_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module  : sa_skew_feeder
// Brief   : Buffers one NxN tile and streams it diagonally skewed onto an array edge.
// Revision: 1.0
// ============================================================================
module sa_skew_feeder
   import sa_skew_feeder_pkg::*;
#(
   parameter int N     = 4,
   parameter int DW    = 32,
   parameter int DRAIN = N + 3
) (
   input  logic             CLK,
   input  logic             RST_N,
   sa_skew_feeder_if.slave  bus
);

   localparam int TW  = clog2(2 * N - 1);
   localparam int DCW = clog2(DRAIN);
   localparam int LW  = clog2(N);

   localparam logic [TW-1:0]  T_LAST = TW'(2 * N - 2);
   localparam logic [DCW-1:0] D_LAST = DCW'(DRAIN - 1);
   localparam logic [LW-1:0]  L_LAST = LW'(N - 1);

   feeder_state_t  state, state_nxt;
   logic [LW-1:0]  ld_cnt, ld_cnt_nxt;
   logic [TW-1:0]  t, t_nxt;
   logic [DCW-1:0] d, d_nxt;
   logic           accept;
   logic           stream_nxt;

   assign bus.LD_READY = (state == ST_EMPTY) || (state == ST_LOAD);
   assign accept       = bus.LD_VALID && bus.LD_READY;

   always_comb begin
      state_nxt  = state;
      ld_cnt_nxt = ld_cnt;
      t_nxt      = t;
      d_nxt      = d;
      unique case (state)
         ST_EMPTY: begin
            if (accept) begin
               state_nxt  = ST_LOAD;
               ld_cnt_nxt = LW'(1);
            end
         end
         ST_LOAD: begin
            if (accept) begin
               ld_cnt_nxt = ld_cnt + 1'b1;
               if (ld_cnt == L_LAST) begin
                  state_nxt  = ST_FULL;
                  ld_cnt_nxt = '0;
               end
            end
         end
         ST_FULL: begin
            if (bus.START) begin
               state_nxt = ST_STREAM;
               t_nxt     = '0;
            end
         end
         ST_STREAM: begin
            if (t == T_LAST) begin
               state_nxt = ST_DRAIN;
               d_nxt     = '0;
            end else begin
               t_nxt = t + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (d == D_LAST) begin
               state_nxt = ST_EMPTY;
               d_nxt     = '0;
            end else begin
               d_nxt = d + 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state  <= ST_EMPTY;
         ld_cnt <= '0;
         t      <= '0;
         d      <= '0;
      end else begin
         state  <= state_nxt;
         ld_cnt <= ld_cnt_nxt;
         t      <= t_nxt;
         d      <= d_nxt;
      end
   end

   assign bus.FEED_VLD = (state == ST_STREAM);
   assign bus.BUSY     = (state == ST_STREAM) || (state == ST_DRAIN);
   assign bus.DONE     = (state == ST_DRAIN) && (d == D_LAST);

   // FEED is registered from the next-cycle counter so the lane value lines up
   // with the cycle in which the FSM actually holds that t.
   assign stream_nxt = (state_nxt == ST_STREAM);

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [DW-1:0] row [N];
      logic [DW-1:0] feed_lane, feed_lane_nxt;
      logic [TW:0]   rel;

      always_ff @(posedge CLK) begin
         if (accept && (ld_cnt == LW'(i))) begin
            for (int k = 0; k < N; k++) begin
               row[k] <= bus.LD_DATA[k*DW +: DW];
            end
         end
      end

      always_comb begin
         rel           = {1'b0, t_nxt} - (TW+1)'(i);
         feed_lane_nxt = DW'(FP_ZERO);
         if (stream_nxt && (t_nxt >= TW'(i)) && (rel < (TW+1)'(N))) begin
            feed_lane_nxt = row[rel[LW-1:0]];
         end
      end

      always_ff @(posedge CLK) begin
         if (!RST_N) feed_lane <= DW'(FP_ZERO);
         else        feed_lane <= feed_lane_nxt;
      end

      assign bus.FEED[i*DW +: DW] = feed_lane;
   end

endmodule
`default_nettype wire

// File: tb/tb_sa_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sa_skew_feeder
// Brief   : Scoreboard bench for the skewed edge feeder (N=4, DRAIN=7).
// Revision: 1.0
// ============================================================================
module tb_sa_skew_feeder;

   localparam int N     = 4;
   localparam int DW    = 32;
   localparam int DRAIN = 7;
   localparam int SLEN  = 2 * N - 1;

   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   logic rst_q = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [N*DW-1:0] feed_q [$];
   int              done_q [$];
   logic [N*DW-1:0] exp_v;
   int              gap    = -1;
   bit              in_run = 1'b0;

   always #5 CLK = ~CLK;

   sa_skew_feeder_if #(.N(N), .DW(DW)) bus ();

   sa_skew_feeder #(.N(N), .DW(DW), .DRAIN(DRAIN)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus.slave)
   );

   // Tile 1 contains -0 at [0][0] to prove bit-exact forwarding.
   function automatic logic [31:0] elem(input int tile, input int r, input int k);
      case (tile)
         0:       return 32'h3F80_0000 + 32'(r << 4) + 32'(k);
         1:       return 32'h8000_0000 + 32'(r << 8) + 32'(k);
         default: return 32'h4040_0000 + 32'(k << 8) + 32'(r);
      endcase
   endfunction

   task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(posedge CLK) rst_q <= RST_N;

   always @(negedge CLK) begin
      if (!rst_q) begin
         check("reset_feed", bus.FEED, '0);
         check("reset_flags", {bus.LD_READY, bus.FEED_VLD, bus.BUSY, bus.DONE}, 4'b1000);
         in_run = 1'b0;
         gap    = -1;
      end else begin
         if (bus.FEED_VLD) begin
            if (feed_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_feed actual=%h required=no_stream", bus.FEED);
            end else begin
               exp_v = feed_q.pop_front();
               check("feed", bus.FEED, exp_v);
            end
            in_run = 1'b1;
            gap    = 0;
         end else begin
            check("feed_idle", bus.FEED, '0);
            if (gap >= 0) gap++;
         end
         check("busy", bus.BUSY, bus.FEED_VLD || in_run);
         if (bus.DONE) begin
            if (done_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               void'(done_q.pop_front());
               check("done_gap", gap, DRAIN);
            end
            in_run = 1'b0;
            gap    = -1;
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_tile(input int tile, input bit gaps, input bit start_mid);
      for (int r = 0; r < N; r++) begin
         bus.LD_VALID = 1'b1;
         for (int k = 0; k < N; k++) bus.LD_DATA[k*DW +: DW] = elem(tile, r, k);
         check("ld_ready", bus.LD_READY, 1'b1);
         tick();
         if (gaps) begin
            bus.LD_VALID = 1'b0;
            bus.LD_DATA  = '1;
            if (start_mid && r == 1) bus.START = 1'b1;
            tick();
            bus.START = 1'b0;
         end
      end
      bus.LD_VALID = 1'b0;
   endtask

   task automatic start_stream(input int tile);
      logic [N*DW-1:0] v;
      for (int t = 0; t < SLEN; t++) begin
         v = '0;
         for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = elem(tile, i, t - i);
         end
         feed_q.push_back(v);
      end
      done_q.push_back(1);
      bus.START = 1'b1;
      tick();
      bus.START = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!bus.DONE && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (!bus.DONE) begin
         failures++;
         $display("FAIL done_timeout actual=0 required=1");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.LD_VALID = 1'b1;
      bus.LD_DATA  = '0;
      bus.START    = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RST_N        = 1'b1;
      bus.LD_VALID = 1'b0;
      bus.START    = 1'b0;
      tick();

      // Plain load and stream
      load_tile(0, 1'b0, 1'b0);
      start_stream(0);
      wait_done();
      tick();

      // Gapped load, ignored START in LOAD, dropped 5th beat
      load_tile(1, 1'b1, 1'b1);
      bus.LD_VALID = 1'b1;
      for (int k = 0; k < N; k++) bus.LD_DATA[k*DW +: DW] = 32'hDEAD_0000 + 32'(k);
      check("ld_ready_full", bus.LD_READY, 1'b0);
      tick();
      bus.LD_VALID = 1'b0;
      repeat (2) tick();
      start_stream(1);
      wait_done();
      tick();

      // Reset while streaming at t=2
      load_tile(0, 1'b0, 1'b0);
      start_stream(0);
      repeat (2) tick();
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      feed_q.delete();
      done_q.delete();
      repeat (12) tick();

      // Back-to-back tiles, reload the cycle after DONE
      load_tile(0, 1'b0, 1'b0);
      start_stream(0);
      wait_done();
      tick();
      load_tile(2, 1'b0, 1'b0);
      start_stream(2);
      wait_done();

      repeat (10) tick();
      check("queues_empty", feed_q.size() + done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
